spi_tx: RTL and testbench

SPI mode-0 master transmitter. It takes bytes from the system side over a valid/ready handshake and serialises them MSB-first on `Sclk`/`Mosi`, framed by an active-low `CSel`. The peer byte receiver samples `Mosi` on rising `Sclk` while `CSel` is low. The block runs entirely in the system clock domain and generates `Sclk` by division.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_clk_div.sv | 38 +++
 rtl/spi_tx.sv | 214 +++++++++++++++++++++
 tb/tb_spi_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 transmitter.
package spi_pkg;

   localparam int unsigned SPI_BITS  = 8;
   localparam logic        SCLK_IDLE = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      HIGH,
      LOW,
      TRAIL,
      GAP
   } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Phase timer: PhaseTick is high in the last of every CLK_DIV cycles, restartable.
module spi_clk_div #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Restart,
   output logic PhaseTick
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // Tick is registered one cycle early so it lines up with cnt_q == CNT_LAST.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (Restart || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end
      tick_d = (cnt_d == CNT_LAST);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt_q  <= '0;
         tick_q <= 1'(CLK_DIV == 1);
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign PhaseTick = tick_q;

endmodule

// File: rtl/spi_tx.sv
// SPI mode-0 master transmitter: valid/ready byte in, MSB-first on Sclk/Mosi framed by CSel.
// Define SPI_TX_BURST_EN to chain bytes accepted in the final bit into one CSel frame.
module spi_tx
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned IDLE_CYC = 2
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [SPI_BITS-1:0] DataIn,
   input  logic                Valid,
   output logic                Ready,
   output logic                Busy,
   output logic                Done,
   output logic                Sclk,
   output logic                Mosi,
   output logic                CSel
);

   localparam int unsigned BIT_W = $clog2(SPI_BITS);
   localparam int unsigned GAP_W = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SPI_BITS - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_CYC - 1);

   spi_state_e          state_q, state_d;
   logic [SPI_BITS-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic                sclk_q, sclk_d;
   logic                mosi_q, mosi_d;
   logic                csel_q, csel_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                accept_c;
   logic                restart_c;
   logic                phase_tick;

`ifdef SPI_TX_BURST_EN
   logic [SPI_BITS-1:0] hold_q, hold_d;
   logic                hold_vld_q, hold_vld_d;
   logic [SPI_BITS-1:0] chain_byte_c;

   // A byte offered on the very edge that ends the last bit bypasses the holding register.
   assign chain_byte_c = hold_vld_q ? hold_q : DataIn;
`endif

   assign accept_c  = Valid && ready_q;
   assign restart_c = (state_d != state_q);

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .Clk       (Clk),
      .Reset     (Reset),
      .Restart   (restart_c),
      .PhaseTick (phase_tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      csel_d    = csel_q;
      ready_d   = ready_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
`ifdef SPI_TX_BURST_EN
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
`endif

      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (accept_c) begin
               shift_d   = DataIn;
               bit_cnt_d = '0;
               mosi_d    = DataIn[SPI_BITS-1];
               csel_d    = 1'b0;
               busy_d    = 1'b1;
               ready_d   = 1'b0;
               state_d   = LEAD;
            end
         end

         LEAD: begin
            if (phase_tick) begin
               sclk_d  = ~SCLK_IDLE;
               state_d = HIGH;
            end
         end

         HIGH: begin
`ifdef SPI_TX_BURST_EN
            if (accept_c) begin
               hold_d     = DataIn;
               hold_vld_d = 1'b1;
               ready_d    = 1'b0;
            end
`endif
            if (phase_tick) begin
               sclk_d  = SCLK_IDLE;
               ready_d = 1'b0;
               if (bit_cnt_q != BIT_LAST) begin
                  shift_d   = shift_q << 1;
                  mosi_d    = shift_q[SPI_BITS-2];
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  state_d   = LOW;
               end else begin
                  state_d = TRAIL;
`ifdef SPI_TX_BURST_EN
                  if (hold_vld_q || accept_c) begin
                     shift_d    = chain_byte_c;
                     mosi_d     = chain_byte_c[SPI_BITS-1];
                     bit_cnt_d  = '0;
                     hold_vld_d = 1'b0;
                     state_d    = LOW;
                  end
`endif
               end
            end
         end

         LOW: begin
            if (phase_tick) begin
               sclk_d  = ~SCLK_IDLE;
               state_d = HIGH;
`ifdef SPI_TX_BURST_EN
               // Open the window for a chained byte during the last high phase.
               if (bit_cnt_q == BIT_LAST) begin
                  ready_d = 1'b1;
               end
`endif
            end
         end

         TRAIL: begin
            if (phase_tick) begin
               csel_d    = 1'b1;
               mosi_d    = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               gap_cnt_d = '0;
               state_d   = GAP;
            end
         end

         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               ready_d = 1'b1;
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end

         default: begin
            state_d   = GAP;
            gap_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= GAP;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         sclk_q    <= SCLK_IDLE;
         mosi_q    <= 1'b0;
         csel_q    <= 1'b1;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         csel_q    <= csel_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

`ifdef SPI_TX_BURST_EN
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
      end
   end
`endif

   assign Ready = ready_q;
   assign Busy  = busy_q;
   assign Done  = done_q;
   assign Sclk  = sclk_q;
   assign Mosi  = mosi_q;
   assign CSel  = csel_q;

endmodule

// File: tb/tb_spi_tx.sv
// Scoreboard bench for spi_tx: accepted bytes are queued and compared against bits
// captured on rising Sclk; frame timing is checked from a negedge-sampled monitor.
module tb_spi_tx;

   localparam int unsigned CLK_DIV  = 4;
   localparam int unsigned IDLE_CYC = 2;

   logic       Clk    = 1'b0;
   logic       Reset  = 1'b1;
   logic [7:0] DataIn = 8'h00;
   logic       Valid  = 1'b0;
   logic       Ready, Busy, Done, Sclk, Mosi, CSel;

   spi_tx #(
      .CLK_DIV  (CLK_DIV),
      .IDLE_CYC (IDLE_CYC)
   ) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .DataIn (DataIn),
      .Valid  (Valid),
      .Ready  (Ready),
      .Busy   (Busy),
      .Done   (Done),
      .Sclk   (Sclk),
      .Mosi   (Mosi),
      .CSel   (CSel)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Monitor state
   logic       p_sclk = 1'b0, p_csel = 1'b1, p_mosi = 1'b0;
   logic [7:0] rx = 8'h00;
   int fall_cyc = 0, rise_csel_cyc = 0;
   int frame_rises = 0, last_frame_rises = 0, total_rises = 0;
   int last_csel_low = 0, last_csel_high = 0;
   int frames = 0, done_cnt = 0, mosi_bad = 0;
   int rise_t[$];

   always @(negedge Clk) begin
      if (Reset) begin
         frame_rises = 0;
         rise_t.delete();
      end else begin
         if (Done) done_cnt++;
         if (p_csel && !CSel) begin
            fall_cyc       = cyc;
            last_csel_high = cyc - rise_csel_cyc;
            frame_rises    = 0;
            rise_t.delete();
         end
         if (Sclk && (Mosi !== p_mosi)) mosi_bad++;
         if (!p_sclk && Sclk) begin
            total_rises++;
            if (!CSel) begin
               rx = {rx[6:0], Mosi};
               frame_rises++;
               rise_t.push_back(cyc);
               if ((frame_rises % 8) == 0) begin
                  if (exp_q.size() == 0) check("sb_unexpected_byte", 32'(rx), 32'hFFFF_FFFF);
                  else                   check("sb_byte", 32'(rx), 32'(exp_q.pop_front()));
               end
            end
         end
         if (!p_csel && CSel) begin
            rise_csel_cyc    = cyc;
            last_csel_low    = cyc - fall_cyc;
            last_frame_rises = frame_rises;
            frames++;
            check("done_with_csel_rise", 32'(Done), 32'd1);
            check("busy_low_at_csel_rise", 32'(Busy), 32'd0);
            check("mosi_idle_at_csel_rise", 32'(Mosi), 32'd0);
         end
      end
      p_sclk = Sclk;
      p_csel = CSel;
      p_mosi = Mosi;
   end

   // Call at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [7:0] b, output int acc);
      int n;
      n      = 0;
      acc    = -1;
      Valid  = 1'b1;
      DataIn = b;
      while (!Ready && n < 3000) begin
         @(negedge Clk);
         n++;
      end
      if (!Ready) begin
         check("accept_timeout", 32'd0, 32'd1);
      end else begin
         acc = cyc;
         exp_q.push_back(b);
         @(negedge Clk);
      end
      Valid  = 1'b0;
      DataIn = 8'($urandom);
   endtask

   task automatic wait_frames(input int target);
      int n;
      n = 0;
      while (frames < target && n < 5000) begin
         @(negedge Clk);
         n++;
      end
      if (frames < target) check("frame_timeout", 32'(frames), 32'(target));
      @(negedge Clk);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int acc0, acc1, d0, f0, r0, n;
      logic [7:0] junk;

      // Reset values and Ready release timing
      repeat (3) @(negedge Clk);
      check("rst_csel",  32'(CSel),  32'd1);
      check("rst_sclk",  32'(Sclk),  32'd0);
      check("rst_mosi",  32'(Mosi),  32'd0);
      check("rst_ready", 32'(Ready), 32'd0);
      check("rst_busy",  32'(Busy),  32'd0);
      check("rst_done",  32'(Done),  32'd0);
      Reset = 1'b0;
      @(negedge Clk);
      check("ready_1cyc_after_rst", 32'(Ready), 32'd0);
      check("csel_idle_after_rst",  32'(CSel),  32'd1);
      @(negedge Clk);
      check("ready_2cyc_after_rst", 32'(Ready), 32'd1);

      // Single byte 0xA5
      d0 = done_cnt;
      f0 = frames;
      send(8'hA5, acc0);
      wait_frames(f0 + 1);
      check("a5_csel_low", 32'(last_csel_low), 32'(17 * CLK_DIV));
      check("a5_rises", 32'(last_frame_rises), 32'd8);
      if (rise_t.size() >= 2) begin
         check("a5_first_rise", 32'(rise_t[0] - fall_cyc), 32'(CLK_DIV));
         check("a5_bit_period", 32'(rise_t[1] - rise_t[0]), 32'(2 * CLK_DIV));
      end else begin
         check("a5_rise_log", 32'(rise_t.size()), 32'd8);
      end
      check("a5_done_pulses", 32'(done_cnt - d0), 32'd1);

      // 0x00 then 0xFF back-to-back
      d0 = done_cnt;
      f0 = frames;
      send(8'h00, acc0);
      send(8'hFF, acc1);
`ifdef SPI_TX_BURST_EN
      wait_frames(f0 + 1);
      check("burst_rises", 32'(last_frame_rises), 32'd16);
      check("burst_csel_low", 32'(last_csel_low), 32'(33 * CLK_DIV));
      if (rise_t.size() >= 9) check("burst_byte_spacing", 32'(rise_t[8] - rise_t[0]), 32'(16 * CLK_DIV));
      else                    check("burst_rise_log", 32'(rise_t.size()), 32'd16);
      check("burst_done_pulses", 32'(done_cnt - d0), 32'd1);
      check("burst_frames", 32'(frames - f0), 32'd1);
`else
      wait_frames(f0 + 2);
      check("b2b_accept_spacing", 32'(acc1 - acc0), 32'(17 * CLK_DIV + IDLE_CYC + 1));
      check("b2b_csel_high", 32'(last_csel_high), 32'(IDLE_CYC + 1));
      check("b2b_rises", 32'(last_frame_rises), 32'd8);
      check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

      // Valid held while Busy must not be accepted early
      f0 = frames;
      send(8'h11, acc0);
      check("busy_during_frame", 32'(Busy), 32'd1);
      check("ready_low_while_busy", 32'(Ready), 32'd0);
      send(8'h3C, acc1);
      check("busy_valid_ignored", 32'(acc1 - acc0), 32'(17 * CLK_DIV + IDLE_CYC + 1));
      wait_frames(f0 + 2);
`endif

      // Reset after 3 Sclk rises
      send(8'h96, acc0);
      n = 0;
      while (frame_rises < 3 && n < 1000) begin
         @(posedge Clk);
         n++;
      end
      if (frame_rises < 3) check("mid_byte_timeout", 32'(frame_rises), 32'd3);
      #2;
      Reset = 1'b1;
      #1;
      check("midrst_csel", 32'(CSel), 32'd1);
      check("midrst_sclk", 32'(Sclk), 32'd0);
      check("midrst_busy", 32'(Busy), 32'd0);
      check("midrst_done", 32'(Done), 32'd0);
      if (exp_q.size() > 0) junk = exp_q.pop_front();
      r0 = total_rises;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      repeat (100) @(negedge Clk);
      check("no_sclk_after_rst", 32'(total_rises), 32'(r0));
      check("csel_high_after_rst", 32'(CSel), 32'd1);
      check("ready_after_midrst", 32'(Ready), 32'd1);

      // Recovery frame
      d0 = done_cnt;
      f0 = frames;
      send(8'h5A, acc0);
      wait_frames(f0 + 1);
      check("recover_rises", 32'(last_frame_rises), 32'd8);
      check("recover_done", 32'(done_cnt - d0), 32'd1);

      check("mosi_stable_while_sclk_high", 32'(mosi_bad), 32'd0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
